// File: rtl/transmitter_pkg.sv
// Shared definitions for the UART transmit stage: FSM states, line levels,
// default frame/buffer sizes and a counter-width helper.
package transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT = 1;
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_FIFO_DEPTH   = 4;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transmitter_fifo.sv
// Byte buffer in front of the UART transmit FSM. Synchronous FIFO with
// pointers wrapping modulo FIFO_DEPTH (power of two) and an occupancy count
// 0..FIFO_DEPTH. Push while full and pop while empty are ignored.
module transmitter_fifo
  import transmitter_pkg::*;
#(
  parameter int  DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int  FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int PTR_W      = cnt_width(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count
);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transmitter.sv
// UART transmit stage: idle-high line, start 0, DATA_BITS data LSB first,
// optional even parity, stop 1. Each bit is held for CLKS_PER_BIT clocks.
// A small FIFO absorbs bursts; frames leave back to back while it has data.
// Optional feature: define TX_PARITY_EN to insert an even-parity bit after
// the data bits (the receiver must be built with the same setting).
//
// state     | meaning
// ST_IDLE   | line idle high, waiting for a buffered byte
// ST_START  | driving the start bit
// ST_DATA   | shifting out payload bits, LSB first
// ST_PARITY | driving the even-parity bit (TX_PARITY_EN only)
// ST_STOP   | driving the stop bit, then next frame or idle
module transmitter
  import transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TXD,
  output logic                 tx_busy
);

  localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W  = cnt_width(DATA_BITS);
  localparam int CNT_W  = cnt_width(FIFO_DEPTH) + 1;

  tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_d;
  logic                 baud_tc;
  logic                 fifo_pop;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;
`ifdef TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && !fifo_full;
  assign baud_tc   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  transmitter_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next state, counters, shifter and the line level for the coming cycle.
  // TXD is registered, so txd_d is the level belonging to state_d.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = TXD;
    fifo_pop = 1'b0;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != ST_IDLE) begin
      baud_d = baud_tc ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
          txd_d    = START_BIT;
`ifdef TX_PARITY_EN
          parity_d = ^fifo_rd_data;
`endif
        end
      end
      ST_START: begin
        if (baud_tc) begin
          bit_d   = '0;
          state_d = ST_DATA;
          txd_d   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_tc) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = parity_q;
`else
            state_d = ST_STOP;
            txd_d   = STOP_BIT;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            txd_d = shift_d[0];
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tc) begin
          state_d = ST_STOP;
          txd_d   = STOP_BIT;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tc) begin
          if (!fifo_empty) begin
            // Next byte starts immediately: no idle bit between frames.
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            bit_d    = '0;
            state_d  = ST_START;
            txd_d    = START_BIT;
`ifdef TX_PARITY_EN
            parity_d = ^fifo_rd_data;
`endif
          end else begin
            state_d = ST_IDLE;
            txd_d   = LINE_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = LINE_IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered line/busy outputs.
  // Reset aborts any frame and forces the line idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      TXD      <= LINE_IDLE;
      tx_busy  <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      TXD      <= txd_d;
      tx_busy  <= (state_q != ST_IDLE) || (fifo_count != '0);
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
